sram_access_arbiter: RTL and testbench

Single-port SRAM access controller shared by the audio recorder (write port) and the DSP/player (read port). It replaces direct steering of the SRAM pins by the top-level FSM state with a request/acknowledge arbiter. The arbiter sequences timed SRAM strobes, inserts bus turnaround, and tracks the highest recorded address so playback knows where the recording ends. It sits between the recorder/DSP blocks and the external SRAM pins in the top level.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_access_arbiter_if.sv | 28 ++
 rtl/sram_arb_pick.sv | 28 ++
 rtl/sram_access_arbiter.sv | 156 +++++++++++++++
 tb/tb_sram_access_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and defaults for the SRAM access arbiter
package sram_arb_pkg;

    localparam int DEF_AW = 20;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_TURN  = 2'd3
    } state_e;

    typedef enum logic {
        PORT_WR = 1'b0,
        PORT_RD = 1'b1
    } port_e;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// rtl/sram_access_arbiter_if.sv - requester-side handshake bundle (recorder write port, DSP read port, end tracker)
interface sram_access_arbiter_if #(
    parameter int AW = 20,
    parameter int DW = 16
) ();
    logic          i_wr_req;
    logic [AW-1:0] i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic          o_wr_ack;
    logic          i_rd_req;
    logic [AW-1:0] i_rd_addr;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_ack;
    logic          i_clr_end;
    logic [AW-1:0] o_rec_end;
    logic          o_rec_any;
    logic          o_busy;

    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_clr_end,
        input  o_wr_ack, o_rd_data, o_rd_ack, o_rec_end, o_rec_any, o_busy
    );

    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_clr_end,
        output o_wr_ack, o_rd_data, o_rd_ack, o_rec_end, o_rec_any, o_busy
    );
endinterface

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - two-way request picker; SRAM_ARB_WR_PRIORITY_EN makes ties always go to write
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic  wr_req_i,
    input  logic  rd_req_i,
    input  port_e last_i,
    output logic  grant_o,
    output port_e port_o
);

    always_comb begin
        grant_o = wr_req_i | rd_req_i;
        port_o  = PORT_RD;
`ifdef SRAM_ARB_WR_PRIORITY_EN
        if (wr_req_i) begin
            port_o = PORT_WR;
        end
`else
        if (wr_req_i && rd_req_i) begin
            port_o = (last_i == PORT_WR) ? PORT_RD : PORT_WR;
        end else if (wr_req_i) begin
            port_o = PORT_WR;
        end
`endif
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - single-port SRAM arbiter with timed strobes, turnaround and record-end tracking
// Optional: SRAM_ARB_WR_PRIORITY_EN (ties always grant write)
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ACC_CYCLES = 2,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sram_access_arbiter_if.slave  bus,
    output logic [AW-1:0]         o_SRAM_ADDR,
    inout  wire  [DW-1:0]         io_SRAM_DQ,
    output logic                  o_SRAM_WE_N,
    output logic                  o_SRAM_OE_N,
    output logic                  o_SRAM_CE_N,
    output logic                  o_SRAM_LB_N,
    output logic                  o_SRAM_UB_N
);

    localparam logic [3:0] CNT_LAST = 4'(ACC_CYCLES - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    port_e         last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          wr_ack_q, wr_ack_d;
    logic          rd_ack_q, rd_ack_d;
    logic [AW-1:0] rec_end_q, rec_end_d;
    logic          rec_any_q, rec_any_d;

    logic  wr_masked, rd_masked, grant, wr_grant;
    port_e port;

    // A requester still holds its request during its ack cycle; masking stops a second grant.
    assign wr_masked = bus.i_wr_req & ~wr_ack_q;
    assign rd_masked = bus.i_rd_req & ~rd_ack_q;

    sram_arb_pick u_pick (
        .wr_req_i (wr_masked),
        .rd_req_i (rd_masked),
        .last_i   (last_q),
        .grant_o  (grant),
        .port_o   (port)
    );

    assign wr_grant = (state_q == S_IDLE) && grant && (port == PORT_WR);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;
        rec_end_d = rec_end_q;
        rec_any_d = rec_any_q;

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    cnt_d  = 4'd0;
                    last_d = port;
                    if (port == PORT_WR) begin
                        state_d = S_WRITE;
                        addr_d  = bus.i_wr_addr;
                        wdata_d = bus.i_wr_data;
                    end else begin
                        state_d = S_READ;
                        addr_d  = bus.i_rd_addr;
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_TURN;
                    wr_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_READ: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_IDLE;
                    rd_ack_d = 1'b1;
                    rdata_d  = io_SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Clear takes effect before a coincident write grant updates the tracker.
        if (bus.i_clr_end) begin
            rec_end_d = '0;
            rec_any_d = 1'b0;
        end
        if (wr_grant) begin
            if (bus.i_clr_end || !rec_any_q || (bus.i_wr_addr > rec_end_q)) begin
                rec_end_d = bus.i_wr_addr;
            end
            rec_any_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            last_q    <= PORT_RD;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rec_end_q <= '0;
            rec_any_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            rec_end_q <= rec_end_d;
            rec_any_q <= rec_any_d;
        end
    end

    assign o_SRAM_ADDR = addr_q;
    assign io_SRAM_DQ  = (state_q == S_WRITE) ? wdata_q : {DW{1'bz}};
    assign o_SRAM_WE_N = (state_q != S_WRITE);
    assign o_SRAM_OE_N = (state_q != S_READ);
    assign o_SRAM_CE_N = (state_q != S_WRITE) && (state_q != S_READ);
    assign o_SRAM_LB_N = o_SRAM_CE_N;
    assign o_SRAM_UB_N = o_SRAM_CE_N;

    assign bus.o_wr_ack  = wr_ack_q;
    assign bus.o_rd_ack  = rd_ack_q;
    assign bus.o_rd_data = rdata_q;
    assign bus.o_rec_end = rec_end_q;
    assign bus.o_rec_any = rec_any_q;
    assign bus.o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - directed self-checking bench for sram_access_arbiter
module tb_sram_access_arbiter;

    logic        clk;
    logic        rst;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n, ce_n, lb_n, ub_n;
    logic [15:0] rd_model;
    int          checks;
    int          failures;

    sram_access_arbiter_if #(.AW(20), .DW(16)) bus ();

    sram_access_arbiter #(.ACC_CYCLES(2), .AW(20), .DW(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_SRAM_ADDR (sram_addr),
        .io_SRAM_DQ  (sram_dq),
        .o_SRAM_WE_N (we_n),
        .o_SRAM_OE_N (oe_n),
        .o_SRAM_CE_N (ce_n),
        .o_SRAM_LB_N (lb_n),
        .o_SRAM_UB_N (ub_n)
    );

    assign sram_dq = (!oe_n) ? rd_model : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [19:0] a, input logic [15:0] d,
                            input logic clr);
        bit got;
        bus.i_wr_req   = 1'b1;
        bus.i_wr_addr  = a;
        bus.i_wr_data  = d;
        bus.i_clr_end  = clr;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            bus.i_clr_end = 1'b0;
            if (bus.o_wr_ack) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_ack"}, {31'd0, got}, 32'd1);
        bus.i_wr_req = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 30; c++) begin
            if (!bus.o_busy && !bus.o_rd_ack && !bus.o_wr_ack) break;
            tick();
        end
        check(tag, {31'd0, bus.o_busy}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},   {31'd0, bus.o_busy},   32'd0);
        check({tag, "_wrack"},  {31'd0, bus.o_wr_ack}, 32'd0);
        check({tag, "_rdack"},  {31'd0, bus.o_rd_ack}, 32'd0);
        check({tag, "_any"},    {31'd0, bus.o_rec_any}, 32'd0);
        check({tag, "_end"},    {12'd0, bus.o_rec_end}, 32'd0);
        check({tag, "_rdata"},  {16'd0, bus.o_rd_data}, 32'd0);
        check({tag, "_addr"},   {12'd0, sram_addr},     32'd0);
        check({tag, "_strb"},   {27'd0, we_n, oe_n, ce_n, lb_n, ub_n}, 32'h1F);
    endtask

    initial begin
        logic [3:0] seq;
        logic       prev_we, prev_oe;
        int         ng;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rd_model = 16'h0000;
        bus.i_wr_req  = 1'b0;
        bus.i_wr_addr = '0;
        bus.i_wr_data = '0;
        bus.i_rd_req  = 1'b0;
        bus.i_rd_addr = '0;
        bus.i_clr_end = 1'b0;
        tick();
        tick();
        check_reset_state("rst");
        rst = 1'b0;
        tick();

        // Single write: grant at next edge, WE_N low 2 cycles, ack in the turn cycle.
        bus.i_wr_req  = 1'b1;
        bus.i_wr_addr = 20'h00010;
        bus.i_wr_data = 16'hBEEF;
        tick();
        check("wr_c1_we",   {31'd0, we_n}, 32'd0);
        check("wr_c1_ce",   {29'd0, ce_n, lb_n, ub_n}, 32'd0);
        check("wr_c1_dq",   {16'd0, sram_dq}, 32'h0000BEEF);
        check("wr_c1_addr", {12'd0, sram_addr}, 32'h00010);
        check("wr_c1_busy", {31'd0, bus.o_busy}, 32'd1);
        check("wr_c1_ack",  {31'd0, bus.o_wr_ack}, 32'd0);
        check("wr_end",     {12'd0, bus.o_rec_end}, 32'h00010);
        check("wr_any",     {31'd0, bus.o_rec_any}, 32'd1);
        tick();
        check("wr_c2_we",   {31'd0, we_n}, 32'd0);
        check("wr_c2_dq",   {16'd0, sram_dq}, 32'h0000BEEF);
        check("wr_c2_ack",  {31'd0, bus.o_wr_ack}, 32'd0);
        tick();
        check("wr_c3_we",   {31'd0, we_n}, 32'd1);
        check("wr_c3_ce",   {31'd0, ce_n}, 32'd1);
        check("wr_c3_ack",  {31'd0, bus.o_wr_ack}, 32'd1);
        check("wr_c3_busy", {31'd0, bus.o_busy}, 32'd1);
        bus.i_wr_req = 1'b0;
        tick();
        check("wr_c4_ack",  {31'd0, bus.o_wr_ack}, 32'd0);
        check("wr_c4_busy", {31'd0, bus.o_busy}, 32'd0);

        // Single read: OE_N low 2 cycles, data and ack in the following idle cycle.
        rd_model      = 16'h1234;
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 20'h00010;
        tick();
        check("rd_c1_oe", {31'd0, oe_n}, 32'd0);
        check("rd_c1_we", {31'd0, we_n}, 32'd1);
        check("rd_c1_ce", {31'd0, ce_n}, 32'd0);
        check("rd_c1_dq", {16'd0, sram_dq}, 32'h00001234);
        tick();
        check("rd_c2_oe",  {31'd0, oe_n}, 32'd0);
        check("rd_c2_ack", {31'd0, bus.o_rd_ack}, 32'd0);
        tick();
        check("rd_c3_oe",   {31'd0, oe_n}, 32'd1);
        check("rd_c3_ack",  {31'd0, bus.o_rd_ack}, 32'd1);
        check("rd_c3_data", {16'd0, bus.o_rd_data}, 32'h00001234);
        check("rd_c3_busy", {31'd0, bus.o_busy}, 32'd0);
        bus.i_rd_req = 1'b0;
        rd_model     = 16'h5A5A;
        tick();
        check("rd_c4_ack",  {31'd0, bus.o_rd_ack}, 32'd0);
        check("rd_c4_hold", {16'd0, bus.o_rd_data}, 32'h00001234);

        // Both requests held: record the order of the first four accesses.
        bus.i_wr_req  = 1'b1;
        bus.i_wr_addr = 20'h00020;
        bus.i_wr_data = 16'h0F0F;
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 20'h00030;
        prev_we = we_n;
        prev_oe = oe_n;
        ng  = 0;
        seq = 4'b0000;
        for (int c = 0; c < 60; c++) begin
            if (ng >= 4) break;
            tick();
            if (!we_n && prev_we) begin
                seq[ng] = 1'b0;
                ng++;
            end else if (!oe_n && prev_oe) begin
                seq[ng] = 1'b1;
                ng++;
            end
            prev_we = we_n;
            prev_oe = oe_n;
        end
        bus.i_wr_req = 1'b0;
        bus.i_rd_req = 1'b0;
        check("tie_count", ng, 32'd4);
`ifdef SRAM_ARB_WR_PRIORITY_EN
        check("tie_order", {28'd0, seq}, 32'b0000);
`else
        check("tie_order", {28'd0, seq}, 32'b1010);
`endif
        wait_idle("tie_idle");
        tick();
        check("tie_end", {12'd0, bus.o_rec_end}, 32'h00020);

        // End tracker: max tracking, clear coincident with a grant, top address.
        do_write("w_ff", 20'h000FF, 16'h1111, 1'b0);
        check("end_ff", {12'd0, bus.o_rec_end}, 32'h000FF);
        do_write("w_05", 20'h00005, 16'h2222, 1'b0);
        check("end_05", {12'd0, bus.o_rec_end}, 32'h000FF);
        do_write("w_03clr", 20'h00003, 16'h3333, 1'b1);
        check("end_clr",  {12'd0, bus.o_rec_end}, 32'h00003);
        check("any_clr",  {31'd0, bus.o_rec_any}, 32'd1);
        bus.i_clr_end = 1'b1;
        tick();
        bus.i_clr_end = 1'b0;
        check("end_clr_only", {12'd0, bus.o_rec_end}, 32'h00000);
        check("any_clr_only", {31'd0, bus.o_rec_any}, 32'd0);
        do_write("w_top", 20'hFFFFF, 16'h4444, 1'b0);
        check("end_top", {12'd0, bus.o_rec_end}, 32'hFFFFF);
        do_write("w_after_top", 20'h00010, 16'h5555, 1'b0);
        check("end_no_wrap", {12'd0, bus.o_rec_end}, 32'hFFFFF);

        // Reset in the second write cycle aborts without an ack.
        bus.i_wr_req  = 1'b1;
        bus.i_wr_addr = 20'h00050;
        bus.i_wr_data = 16'h6666;
        tick();
        tick();
        check("abort_we_before", {31'd0, we_n}, 32'd0);
        rst = 1'b1;
        bus.i_wr_req = 1'b0;
        tick();
        check_reset_state("abort");
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("abort_no_ack", {31'd0, bus.o_wr_ack}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
